// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side signals of the byte-serial memory controller.
// A requester raises *_req_in with stable fields and holds them until the matching one-cycle *_ack_out pulse.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
  logic              rdy_in;
  logic              if_req_in;
  logic [ADDR_W-1:0] if_addr_in;
  logic              if_ack_out;
  logic [31:0]       if_inst_out;
  logic              mem_req_in;
  logic              mem_we_in;
  logic [ADDR_W-1:0] mem_addr_in;
  logic [2:0]        mem_len_in;
  logic              mem_signed_in;
  logic [31:0]       mem_wdata_in;
  logic              mem_ack_out;
  logic [31:0]       mem_rdata_out;
  logic [ADDR_W-1:0] ram_a_out;
  logic              ram_wr_out;
  logic [7:0]        ram_dout_out;
  logic [7:0]        ram_din_in;
  logic [1:0]        dbg_state;

  modport slave (
    input  rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_addr_in,
           mem_len_in, mem_signed_in, mem_wdata_in, ram_din_in,
    output if_ack_out, if_inst_out, mem_ack_out, mem_rdata_out,
           ram_a_out, ram_wr_out, ram_dout_out, dbg_state
  );

  modport master (
    output rdy_in, if_req_in, if_addr_in, mem_req_in, mem_we_in, mem_addr_in,
           mem_len_in, mem_signed_in, mem_wdata_in, ram_din_in,
    input  if_ack_out, if_inst_out, mem_ack_out, mem_rdata_out,
           ram_a_out, ram_wr_out, ram_dout_out, dbg_state
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns IF fetches and MEM loads/stores into
// 8-bit RAM accesses, MEM having priority, with little-endian sign/zero extension.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  mem_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        len_q;
  logic              src_if;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;
  logic [ADDR_W-1:0] ram_a_q;
  logic [ADDR_W-1:0] ram_a_prev;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;
  logic [31:0]       rdata_q;
  logic [31:0]       inst_q;

  logic              accept_mem, accept_if, last_rd, last_wr;
  logic [1:0]        cap_idx, wr_idx;
  logic [2:0]        req_len;
  logic [31:0]       rword, rext;

  always_comb begin
    state_nxt  = state;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    last_rd    = 1'b0;
    last_wr    = 1'b0;
    cap_idx    = 2'(cnt - 3'd1);
    wr_idx     = 2'(cnt + 3'd1);
    req_len    = (bus.mem_len_in == 3'd1 || bus.mem_len_in == 3'd2) ? bus.mem_len_in : 3'd4;
    rword      = rbuf;
    rword[{cap_idx, 3'b000} +: 8] = bus.ram_din_in;
    rext       = rword;
    if (!src_if) begin
      case (len_q)
        3'd1:    rext = {{24{signed_q & rword[7]}}, rword[7:0]};
        3'd2:    rext = {{16{signed_q & rword[15]}}, rword[15:0]};
        default: rext = rword;
      endcase
    end
    case (state)
      IDLE: begin
        if (bus.mem_req_in) begin
          accept_mem = 1'b1;
          state_nxt  = bus.mem_we_in ? WR : RD;
        end else if (bus.if_req_in) begin
          accept_if = 1'b1;
          state_nxt = RD;
        end
      end
      // Byte cnt-1 is on ram_din_in while address cnt is presented; done once cnt reaches len.
      RD: begin
        if (cnt == len_q) begin
          last_rd   = 1'b1;
          state_nxt = DONE;
        end
      end
      WR: begin
        if ((cnt + 3'd1) == len_q) begin
          last_wr   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      len_q      <= 3'd0;
      src_if     <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= 32'd0;
      rbuf       <= 32'd0;
      ram_a_q    <= '0;
      ram_a_prev <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= 8'd0;
      rdata_q    <= 32'd0;
      inst_q     <= 32'd0;
    end else if (bus.rdy_in) begin
      state      <= state_nxt;
      ram_a_prev <= ram_a_q;
      case (state)
        IDLE: begin
          if (accept_mem || accept_if) begin
            src_if     <= accept_if;
            cnt        <= 3'd0;
            rbuf       <= 32'd0;
            ram_a_q    <= accept_mem ? bus.mem_addr_in : bus.if_addr_in;
            len_q      <= accept_mem ? req_len : 3'd4;
            signed_q   <= accept_mem & bus.mem_signed_in;
            wdata_q    <= bus.mem_wdata_in;
            ram_wr_q   <= accept_mem & bus.mem_we_in;
            ram_dout_q <= bus.mem_wdata_in[7:0];
          end
        end
        RD: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) rbuf <= rword;
          if ((cnt + 3'd1) < len_q) ram_a_q <= ram_a_q + A_ONE;
          if (last_rd) begin
            if (src_if) inst_q <= rext;
            else        rdata_q <= rext;
          end
        end
        WR: begin
          if (last_wr) begin
            ram_wr_q <= 1'b0;
          end else begin
            cnt        <= cnt + 3'd1;
            ram_a_q    <= ram_a_q + A_ONE;
            ram_dout_q <= wdata_q[{wr_idx, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // While stalled the previous address is shown again, so the byte still owed
  // is what the RAM returns in the first cycle after the stall.
  assign bus.ram_a_out     = bus.rdy_in ? ram_a_q : ram_a_prev;
  assign bus.ram_wr_out    = ram_wr_q & bus.rdy_in;
  assign bus.ram_dout_out  = ram_dout_q;
  assign bus.mem_ack_out   = (state == DONE) && bus.rdy_in && !src_if;
  assign bus.if_ack_out    = (state == DONE) && bus.rdy_in && src_if;
  assign bus.mem_rdata_out = rdata_q;
  assign bus.if_inst_out   = inst_q;
  assign bus.dbg_state     = state;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM model that returns data one cycle after the address.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  mem_ctrl_if #(.ADDR_W(32)) bus();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  logic       pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.ram_wr_out) ram[bus.ram_a_out[9:0]] <= bus.ram_dout_out;
    bus.ram_din_in <= ram[bus.ram_a_out[9:0]];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    preload(10'h100, 8'h78); preload(10'h101, 8'h56);
    preload(10'h102, 8'h34); preload(10'h103, 8'h12);
    preload(10'h040, 8'h80);
    preload(10'h300, 8'hEF); preload(10'h301, 8'hBE);
    preload(10'h302, 8'hAD); preload(10'h303, 8'hDE);
    @(negedge clk);
    checks++;
    if ({bus.if_ack_out, bus.mem_ack_out, bus.ram_wr_out} !== 3'b000) begin
      failures++; $display("FAIL reset_acks got=%b exp=000", {bus.if_ack_out, bus.mem_ack_out, bus.ram_wr_out});
    end
    checks++;
    if ({bus.if_inst_out, bus.mem_rdata_out} !== 64'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus.if_inst_out, bus.mem_rdata_out});
    end
    checks++;
    if ({bus.ram_a_out, bus.ram_dout_out, bus.dbg_state} !== 42'd0) begin
      failures++; $display("FAIL reset_ram got=%h exp=0", {bus.ram_a_out, bus.ram_dout_out, bus.dbg_state});
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_load_word();
    logic [31:0] exp_a;
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_addr_in = 32'h100;
    bus.mem_len_in = 3'd4; bus.mem_signed_in = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 6)) begin
        failures++; $display("FAIL load_word_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 6));
      end
      checks++;
      if (bus.ram_wr_out !== 1'b0) begin
        failures++; $display("FAIL load_word_wr cycle=%0d got=%b exp=0", c, bus.ram_wr_out);
      end
      if (c >= 1 && c <= 4) begin
        exp_a = 32'h100 + 32'(c - 1);
        checks++;
        if (bus.ram_a_out !== exp_a) begin
          failures++; $display("FAIL load_word_addr cycle=%0d got=%h exp=%h", c, bus.ram_a_out, exp_a);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_rdata_out !== 32'h12345678) begin
          failures++; $display("FAIL load_word_data got=%h exp=12345678", bus.mem_rdata_out);
        end
      end
      next_cycle();
      if (c == 6) bus.mem_req_in = 1'b0;
    end
  endtask

  task automatic test_load_byte();
    logic [31:0] exp_d;
    for (int s = 1; s >= 0; s--) begin
      exp_d = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
      bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_addr_in = 32'h40;
      bus.mem_len_in = 3'd1; bus.mem_signed_in = (s == 1);
      for (int c = 0; c <= 5; c++) begin
        @(negedge clk);
        checks++;
        if (bus.mem_ack_out !== (c == 3)) begin
          failures++; $display("FAIL load_byte_ack signed=%0d cycle=%0d got=%b exp=%b", s, c, bus.mem_ack_out, (c == 3));
        end
        if (c == 3) begin
          checks++;
          if (bus.mem_rdata_out !== exp_d) begin
            failures++; $display("FAIL load_byte_data signed=%0d got=%h exp=%h", s, bus.mem_rdata_out, exp_d);
          end
        end
        next_cycle();
        if (c == 3) bus.mem_req_in = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_addr_in = 32'h100;
    bus.mem_len_in = 3'd4; bus.mem_signed_in = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      bus.rdy_in = !(c >= 3 && c <= 5);
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 9)) begin
        failures++; $display("FAIL stall_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 9));
      end
      checks++;
      if (bus.ram_wr_out !== 1'b0) begin
        failures++; $display("FAIL stall_wr cycle=%0d got=%b exp=0", c, bus.ram_wr_out);
      end
      if (c == 9) begin
        checks++;
        if (bus.mem_rdata_out !== 32'h12345678) begin
          failures++; $display("FAIL stall_data got=%h exp=12345678", bus.mem_rdata_out);
        end
      end
      next_cycle();
      if (c == 9) bus.mem_req_in = 1'b0;
    end
    bus.rdy_in = 1'b1;
  endtask

  task automatic test_store_half();
    logic [31:0] exp_a [0:1] = '{32'h202, 32'h203};
    logic [7:0]  exp_d [0:1] = '{8'hEF, 8'hBE};
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_addr_in = 32'h202;
    bus.mem_len_in = 3'd2; bus.mem_signed_in = 1'b0; bus.mem_wdata_in = 32'h1234BEEF;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 3)) begin
        failures++; $display("FAIL store_half_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 3));
      end
      checks++;
      if (bus.ram_wr_out !== (c == 1 || c == 2)) begin
        failures++; $display("FAIL store_half_wr cycle=%0d got=%b exp=%b", c, bus.ram_wr_out, (c == 1 || c == 2));
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (bus.ram_a_out !== exp_a[c-1] || bus.ram_dout_out !== exp_d[c-1]) begin
          failures++; $display("FAIL store_half_byte cycle=%0d got=%h/%h exp=%h/%h", c, bus.ram_a_out, bus.ram_dout_out, exp_a[c-1], exp_d[c-1]);
        end
      end
      next_cycle();
      if (c == 3) bus.mem_req_in = 1'b0;
    end
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 4)) begin
        failures++; $display("FAIL readback_half_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 4));
      end
      if (c == 4) begin
        checks++;
        if (bus.mem_rdata_out !== 32'h0000BEEF) begin
          failures++; $display("FAIL readback_half_data got=%h exp=0000beef", bus.mem_rdata_out);
        end
      end
      next_cycle();
      if (c == 4) bus.mem_req_in = 1'b0;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [0:3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    logic [7:0]  exp_d [0:3] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_addr_in = 32'hFFFFFFFE;
    bus.mem_len_in = 3'd7; bus.mem_wdata_in = 32'hA1B2C3D4;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 5)) begin
        failures++; $display("FAIL wrap_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 5));
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (bus.ram_wr_out !== 1'b1 || bus.ram_a_out !== exp_a[c-1] || bus.ram_dout_out !== exp_d[c-1]) begin
          failures++; $display("FAIL wrap_byte cycle=%0d got=%b/%h/%h exp=1/%h/%h", c, bus.ram_wr_out, bus.ram_a_out, bus.ram_dout_out, exp_a[c-1], exp_d[c-1]);
        end
      end
      next_cycle();
      if (c == 5) bus.mem_req_in = 1'b0;
    end
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_len_in = 3'd4;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 6) begin
        checks++;
        if (bus.mem_ack_out !== 1'b1 || bus.mem_rdata_out !== 32'hA1B2C3D4) begin
          failures++; $display("FAIL wrap_readback got=%b/%h exp=1/a1b2c3d4", bus.mem_ack_out, bus.mem_rdata_out);
        end
      end
      next_cycle();
      if (c == 6) bus.mem_req_in = 1'b0;
    end
  endtask

  task automatic test_priority();
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_addr_in = 32'h100;
    bus.mem_len_in = 3'd4; bus.mem_signed_in = 1'b1;
    bus.if_req_in = 1'b1; bus.if_addr_in = 32'h300;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 6)) begin
        failures++; $display("FAIL prio_mem_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 6));
      end
      checks++;
      if (bus.if_ack_out !== (c == 13)) begin
        failures++; $display("FAIL prio_if_ack cycle=%0d got=%b exp=%b", c, bus.if_ack_out, (c == 13));
      end
      if (c == 6) begin
        checks++;
        if (bus.mem_rdata_out !== 32'h12345678) begin
          failures++; $display("FAIL prio_mem_data got=%h exp=12345678", bus.mem_rdata_out);
        end
      end
      if (c == 8) begin
        checks++;
        if (bus.ram_a_out !== 32'h300) begin
          failures++; $display("FAIL prio_if_addr got=%h exp=00000300", bus.ram_a_out);
        end
      end
      if (c == 13) begin
        checks++;
        if (bus.if_inst_out !== 32'hDEADBEEF) begin
          failures++; $display("FAIL prio_if_inst got=%h exp=deadbeef", bus.if_inst_out);
        end
      end
      next_cycle();
      if (c == 6) bus.mem_req_in = 1'b0;
      if (c == 13) bus.if_req_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid_store();
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b1; bus.mem_addr_in = 32'h210;
    bus.mem_len_in = 3'd4; bus.mem_wdata_in = 32'hCAFEF00D;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    bus.mem_req_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ram_wr_out, bus.mem_ack_out, bus.if_ack_out} !== 3'b000) begin
      failures++; $display("FAIL rst_mid_ctrl got=%b exp=000", {bus.ram_wr_out, bus.mem_ack_out, bus.if_ack_out});
    end
    checks++;
    if ({bus.ram_a_out, bus.ram_dout_out, bus.dbg_state} !== 42'd0) begin
      failures++; $display("FAIL rst_mid_ram got=%h exp=0", {bus.ram_a_out, bus.ram_dout_out, bus.dbg_state});
    end
    checks++;
    if ({bus.mem_rdata_out, bus.if_inst_out} !== 64'd0) begin
      failures++; $display("FAIL rst_mid_data got=%h exp=0", {bus.mem_rdata_out, bus.if_inst_out});
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== 1'b0 || bus.dbg_state !== 2'd0) begin
        failures++; $display("FAIL rst_mid_after cycle=%0d got=%b/%0d exp=0/0", c, bus.mem_ack_out, bus.dbg_state);
      end
      next_cycle();
    end
    bus.mem_req_in = 1'b1; bus.mem_we_in = 1'b0; bus.mem_addr_in = 32'h40;
    bus.mem_len_in = 3'd1; bus.mem_signed_in = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_ack_out !== (c == 3)) begin
        failures++; $display("FAIL rst_mid_load_ack cycle=%0d got=%b exp=%b", c, bus.mem_ack_out, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (bus.mem_rdata_out !== 32'h00000080) begin
          failures++; $display("FAIL rst_mid_load_data got=%h exp=00000080", bus.mem_rdata_out);
        end
      end
      next_cycle();
      if (c == 3) bus.mem_req_in = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.rdy_in = 1'b1;
    bus.if_req_in = 1'b0; bus.if_addr_in = '0;
    bus.mem_req_in = 1'b0; bus.mem_we_in = 1'b0; bus.mem_addr_in = '0;
    bus.mem_len_in = 3'd4; bus.mem_signed_in = 1'b0; bus.mem_wdata_in = '0;
    #1;
    test_reset();
    test_load_word();
    test_load_byte();
    test_stall();
    test_store_half();
    test_wrap();
    test_priority();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
